// File: rtl/hub75_bcm_driver.sv
// HUB75 line driver: BCM bit-planes shown from a two-entry line buffer.
// Define HUB75_DEADTIME_EN to blank DEAD_CYCLES around every latch.
module hub75_bcm_driver #(
   parameter int NUM_PIX     = 64,
   parameter int SCAN_RATE   = 32,
   parameter int RGB_RES     = 9,
   parameter int BASE_ON     = 8,
   parameter int DEAD_CYCLES = 2,
   localparam int ADDR_W     = $clog2(SCAN_RATE)
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic [ADDR_W-1:0]                    col_index,
   input  logic [1:0][NUM_PIX-1:0][RGB_RES-1:0] column_data,
   input  logic                                 tvalid,
   output logic                                 tready,
   output logic [ADDR_W-1:0]                    addr,
   output logic [2:0]                           rgb0,
   output logic [2:0]                           rgb1,
   output logic                                 led_clk,
   output logic                                 led_latch,
   output logic                                 led_output_enable,
   output logic                                 line_done
);
   localparam int BPC    = RGB_RES / 3;
   localparam int PLW    = $clog2(BPC) + 1;
   localparam int PXW    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
   localparam int MAX_ON = BASE_ON << (BPC - 1);
   localparam int CW     = $clog2(MAX_ON + DEAD_CYCLES + 1) + 1;
`ifdef HUB75_DEADTIME_EN
   localparam int BLANK_LEN = (DEAD_CYCLES > 1) ? DEAD_CYCLES : 1;
   localparam int TAIL_LEN  = DEAD_CYCLES;
`else
   localparam int BLANK_LEN = 1;
   localparam int TAIL_LEN  = 0;
`endif

   generate
      if (RGB_RES % 3 != 0 || RGB_RES == 0) begin : g_bad_res
         $error("RGB_RES must be a non-zero multiple of 3");
      end
   endgenerate

   typedef logic [1:0][NUM_PIX-1:0][RGB_RES-1:0] line_t;
   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_SHOW, S_NEXT
   } state_t;

   state_t            state_q, state_d;
   logic [PXW-1:0]    pix_q, pix_d;
   logic              phase_q, phase_d;
   logic [PLW-1:0]    plane_q, plane_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   line_t             act_q, act_d, shd_q, shd_d;
   logic [ADDR_W-1:0] act_addr_q, act_addr_d;
   logic [ADDR_W-1:0] shd_addr_q, shd_addr_d;
   logic              shd_full_q, shd_full_d;
   logic              tready_q, tready_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        rgb0_q, rgb0_d, rgb1_q, rgb1_d;
   logic              clk_q, clk_d, latch_q, latch_d;
   logic              oe_q, oe_d, done_q, done_d;

   logic              accept, promote, in_shift;
   logic [CW-1:0]     on_len, show_end;
   logic [BPC-1:0]    msk;
   logic [RGB_RES-1:0] px0, px1;

   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      phase_d    = phase_q;
      plane_d    = plane_q;
      cnt_d      = cnt_q;
      act_d      = act_q;
      act_addr_d = act_addr_q;
      shd_d      = shd_q;
      shd_addr_d = shd_addr_q;
      accept     = tvalid && tready_q;
      promote    = 1'b0;
      on_len     = CW'(BASE_ON) << plane_q;
      show_end   = on_len + CW'(TAIL_LEN) - CW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (shd_full_q) promote = 1'b1;
         end
         S_SHIFT: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (pix_q == '0) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
               end else begin
                  pix_d = pix_q - 1'b1;
               end
            end
         end
         S_BLANK: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(BLANK_LEN - 1)) state_d = S_LATCH;
         end
         S_LATCH: begin
            state_d = S_SHOW;
            cnt_d   = '0;
         end
         S_SHOW: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == show_end) begin
               if (plane_q == PLW'(BPC - 1)) begin
                  state_d = S_NEXT;
               end else begin
                  state_d = S_SHIFT;
                  plane_d = plane_q + 1'b1;
                  pix_d   = PXW'(NUM_PIX - 1);
                  phase_d = 1'b0;
               end
            end
         end
         S_NEXT: begin
            if (shd_full_q) promote = 1'b1;
            else state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (promote) begin
         state_d    = S_SHIFT;
         plane_d    = '0;
         pix_d      = PXW'(NUM_PIX - 1);
         phase_d    = 1'b0;
         act_d      = shd_q;
         act_addr_d = shd_addr_q;
      end
      if (accept) begin
         shd_d      = column_data;
         shd_addr_d = col_index;
      end
      shd_full_d = (shd_full_q && !promote) || accept;
      tready_d   = !shd_full_d;

      // pin outputs trail the FSM by one register stage
      in_shift = (state_q == S_SHIFT);
      msk      = BPC'(1) << plane_q;
      px0      = act_q[0][pix_q];
      px1      = act_q[1][pix_q];
      rgb0_d   = 3'b000;
      rgb1_d   = 3'b000;
      if (in_shift) begin
         rgb0_d = {|(px0[3*BPC-1 -: BPC] & msk),
                   |(px0[2*BPC-1 -: BPC] & msk),
                   |(px0[BPC-1:0] & msk)};
         rgb1_d = {|(px1[3*BPC-1 -: BPC] & msk),
                   |(px1[2*BPC-1 -: BPC] & msk),
                   |(px1[BPC-1:0] & msk)};
      end
      clk_d   = in_shift && phase_q;
      latch_d = (state_q == S_LATCH);
      addr_d  = latch_d ? act_addr_q : addr_q;
      oe_d    = !((state_q == S_SHOW) && (cnt_q < on_len));
      done_d  = (state_q == S_NEXT);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         pix_q      <= '0;
         phase_q    <= 1'b0;
         plane_q    <= '0;
         cnt_q      <= '0;
         act_q      <= '0;
         act_addr_q <= '0;
         shd_q      <= '0;
         shd_addr_q <= '0;
         shd_full_q <= 1'b0;
         tready_q   <= 1'b1;
         addr_q     <= '0;
         rgb0_q     <= 3'b000;
         rgb1_q     <= 3'b000;
         clk_q      <= 1'b0;
         latch_q    <= 1'b0;
         oe_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         phase_q    <= phase_d;
         plane_q    <= plane_d;
         cnt_q      <= cnt_d;
         act_q      <= act_d;
         act_addr_q <= act_addr_d;
         shd_q      <= shd_d;
         shd_addr_q <= shd_addr_d;
         shd_full_q <= shd_full_d;
         tready_q   <= tready_d;
         addr_q     <= addr_d;
         rgb0_q     <= rgb0_d;
         rgb1_q     <= rgb1_d;
         clk_q      <= clk_d;
         latch_q    <= latch_d;
         oe_q       <= oe_d;
         done_q     <= done_d;
      end
   end

   assign tready            = tready_q;
   assign addr              = addr_q;
   assign rgb0              = rgb0_q;
   assign rgb1              = rgb1_q;
   assign led_clk           = clk_q;
   assign led_latch         = latch_q;
   assign led_output_enable = oe_q;
   assign line_done         = done_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Scoreboard bench for hub75_bcm_driver: a line-level model predicts
// every shift, latch, lit window and line_done with its cycle.
module tb_hub75_bcm_driver;
   localparam int NP   = 4;
   localparam int SR   = 32;
   localparam int RES  = 6;
   localparam int BON  = 4;
   localparam int DEAD = 2;
   localparam int BPC  = RES / 3;
   localparam int AW   = $clog2(SR);
`ifdef HUB75_DEADTIME_EN
   localparam int BL = (DEAD > 1) ? DEAD : 1;
   localparam int TL = DEAD;
`else
   localparam int BL = 1;
   localparam int TL = 0;
`endif
   localparam int EV_SHIFT = 0;
   localparam int EV_LATCH = 1;
   localparam int EV_OE    = 2;
   localparam int EV_DONE  = 3;

   typedef logic [1:0][NP-1:0][RES-1:0] line_t;
   typedef struct { int kind; int val; int cyc; } ev_t;

   logic clk = 1'b0;
   logic rst_in;
   logic [AW-1:0] col_index;
   line_t column_data;
   logic tvalid, tready;
   logic [AW-1:0] addr;
   logic [2:0] rgb0, rgb1;
   logic led_clk, led_latch, led_output_enable, line_done;

   hub75_bcm_driver #(
      .NUM_PIX(NP), .SCAN_RATE(SR), .RGB_RES(RES),
      .BASE_ON(BON), .DEAD_CYCLES(DEAD)
   ) dut (
      .clk_in(clk), .rst_in(rst_in), .col_index(col_index),
      .column_data(column_data), .tvalid(tvalid), .tready(tready),
      .addr(addr), .rgb0(rgb0), .rgb1(rgb1), .led_clk(led_clk),
      .led_latch(led_latch), .led_output_enable(led_output_enable),
      .line_done(line_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ev_t sb[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  last_done = -100;
   int  last_r = -100;
   bit  have_prev = 0;

   task automatic cmp(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                  nm, got, exp, cyc);
      end
   endtask

   function automatic int rgb_bits(input int px, input int b);
      return (((px >> (2*BPC + b)) & 1) << 2) |
             (((px >> (BPC + b)) & 1) << 1) |
             ((px >> b) & 1);
   endfunction

   // Whole-line prediction: first led_clk rise is 3 cycles after the
   // accept, or 2 cycles after the previous line_done, whichever is later.
   task automatic push_line(input line_t d, input int col,
                            input int t, output int r);
      int off, on, v;
      r = (t + 3 > last_done + 2) ? t + 3 : last_done + 2;
      if (have_prev) cmp("accept_after_promote", int'(t >= last_r - 1), 1);
      off = 0;
      for (int b = 0; b < BPC; b++) begin
         on = BON << b;
         for (int k = 0; k < NP; k++) begin
            v = (rgb_bits(int'(d[0][NP-1-k]), b) << 3) |
                rgb_bits(int'(d[1][NP-1-k]), b);
            sb.push_back('{EV_SHIFT, v, r + off + 2*k});
         end
         sb.push_back('{EV_LATCH, col, r - 1 + off + 2*NP + BL});
         sb.push_back('{EV_OE, on, r + off + 2*NP + BL + on});
         off += 2*NP + BL + 1 + on + TL;
      end
      sb.push_back('{EV_DONE, 0, r - 1 + off});
      last_done = r - 1 + off;
      last_r    = r;
      have_prev = 1;
   endtask

   task automatic check_ev(input int kind, input int val);
      ev_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, required none",
                  kind, val, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.val != val || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                     kind, val, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: turns pin activity into events and checks them in order.
   bit p_clk = 0, p_lat = 0, p_oe = 1;
   int oe_start = 0;
   always @(negedge clk) begin
      if (rst_in !== 1'b0) begin
         p_clk = 0;
         p_lat = 0;
         p_oe  = 1;
      end else begin
         if (led_clk && !p_clk) check_ev(EV_SHIFT, int'({rgb0, rgb1}));
         if (led_latch && !p_lat) check_ev(EV_LATCH, int'(addr));
         if (!led_output_enable && p_oe) oe_start = cyc;
         if (led_output_enable && !p_oe) check_ev(EV_OE, cyc - oe_start);
         if (!led_output_enable)
            cmp("lanes_quiet_when_lit", int'({rgb0, rgb1, led_clk}), 0);
         if (line_done) check_ev(EV_DONE, 0);
         p_clk = led_clk;
         p_lat = led_latch;
         p_oe  = led_output_enable;
      end
   end

   task automatic check_reset(input string nm);
      cmp({nm, "_rgb0"}, int'(rgb0), 0);
      cmp({nm, "_rgb1"}, int'(rgb1), 0);
      cmp({nm, "_led_clk"}, int'(led_clk), 0);
      cmp({nm, "_latch"}, int'(led_latch), 0);
      cmp({nm, "_oe"}, int'(led_output_enable), 1);
      cmp({nm, "_addr"}, int'(addr), 0);
      cmp({nm, "_line_done"}, int'(line_done), 0);
      cmp({nm, "_tready"}, int'(tready), 1);
   endtask

   function automatic line_t rand_line();
      line_t l;
      for (int h = 0; h < 2; h++)
         for (int p = 0; p < NP; p++)
            l[h][p] = RES'($urandom);
      return l;
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge
   // with tvalid still high.
   task automatic send(input line_t d, input int col, output int r);
      bit ok = 0;
      column_data = d;
      col_index   = AW'(col);
      tvalid      = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (tready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      r = 0;
      if (!ok) cmp("accept_timeout", 0, 1);
      else push_line(d, col, cyc + 1, r);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
      cmp("drain_empty", sb.size(), 0);
      repeat (4) @(negedge clk);
      cmp("idle_oe", int'(led_output_enable), 1);
      cmp("idle_tready", int'(tready), 1);
      cmp("idle_led_clk", int'(led_clk), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      line_t d;
      int r, ra, tgt;
      rst_in = 1'b0;
      tvalid = 1'b0;
      col_index = '0;
      column_data = '0;
      #2 rst_in = 1'b1;
      #1 check_reset("reset_async");
      repeat (3) @(negedge clk);
      rst_in = 1'b0;

      // single directed line
      d = '0;
      d[0][3] = 6'b10_00_01;
      send(d, 5, r);
      tvalid = 1'b0;
      drain();

      // second line offered while the first is shifting
      send(rand_line(), 9, r);
      tvalid = 1'b0;
      repeat (6) @(negedge clk);
      send(rand_line(), 6, r);
      cmp("tready_shadow_full", int'(tready), 0);
      tvalid = 1'b0;
      drain();

      // tvalid held high across back-to-back lines
      for (int i = 0; i < 4; i++) send(rand_line(), $urandom_range(0, SR-1), r);
      tvalid = 1'b0;
      drain();

      // reset in the middle of plane 1's lit window, shadow full
      send(rand_line(), 12, ra);
      tvalid = 1'b0;
      send(rand_line(), 13, r);
      tvalid = 1'b0;
      tgt = ra + (2*NP + BL + 1 + BON + TL) + 2*NP + BL + 3;
      for (int i = 0; i < 300 && cyc < tgt; i++) @(negedge clk);
      cmp("show_plane1_lit", int'(led_output_enable), 0);
      #2 rst_in = 1'b1;
      #1 check_reset("reset_mid_show");
      sb.delete();
      have_prev = 0;
      last_done = -100;
      repeat (2) @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);
      send(rand_line(), 21, r);
      tvalid = 1'b0;
      drain();

      // random traffic with random gaps
      for (int i = 0; i < 6; i++) begin
         send(rand_line(), $urandom_range(0, SR-1), r);
         tvalid = 1'b0;
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
